// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master.
// State encoding and the default ack-timeout limit.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned TO_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/wb_ack_timer.sv
// Ack-timeout counter for wb_cmd_master.
// Only instantiated when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_ack_timer
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW =
        (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Command/response front end driving a Wishbone classic master port.
// Define WB_CMD_MASTER_TIMEOUT_EN to enable the ack timeout (rsp_err_o).
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned ADR_W     = 32,
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    output logic               busy_o
);

    if (TO_CYCLES < 2) begin : g_bad_to
        $error("wb_cmd_master: TO_CYCLES must be at least 2");
    end

    state_e state_q, state_d;

    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [DAT_W/8-1:0] sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;

    logic accept;
    logic timeout;

    assign accept = (state_q == IDLE) && cmd_valid_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic expire;

    wb_ack_timer #(
        .TO_CYCLES(TO_CYCLES)
    ) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clr_i    (accept),
        .en_i     ((state_q == BUS) && !wbm_ack_i),
        .expire_o (expire)
    );

    // A late ack on the expiry edge still counts as a normal completion.
    assign timeout = (state_q == BUS) && expire && !wbm_ack_i;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid_i) state_d = BUS;
            BUS:     if (wbm_ack_i || timeout) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cyc_d = 1'b1;
                    we_d  = cmd_we_i;
                    sel_d = cmd_sel_i;
                    adr_d = cmd_adr_i;
                    dat_d = cmd_dat_i;
                end
            end
            BUS: begin
                if (wbm_ack_i || timeout) begin
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = '0;
                    adr_d     = '0;
                    dat_d     = '0;
                    rsp_dat_d = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                    rsp_err_d = timeout;
                end
            end
            default: ;
        endcase
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master.
// Timeout cases follow WB_CMD_MASTER_TIMEOUT_EN (TO_CYCLES = 16).
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        busy;

    int errs   = 0;
    int checks = 0;
    int n;
    bit st;
    bit bad;

    wb_cmd_master #(
        .ADR_W(32), .DAT_W(32), .TO_CYCLES(16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (rdat),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_sel   = s;
        cmd_adr   = a;
        cmd_dat   = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Acks in stb cycle ack_at (0 = never); counts cyc cycles.
    task automatic bus_resp(input int ack_at, input logic [31:0] d,
                            output int ncyc, output bit stable);
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        w0;
        a0 = adr; d0 = wdat; s0 = sel; w0 = we;
        ncyc = 0;
        stable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!cyc) break;
            ncyc++;
            if (!stb || adr !== a0 || wdat !== d0 ||
                sel !== s0 || we !== w0) stable = 1'b0;
            ack  = (ncyc == ack_at);
            rdat = (ncyc == ack_at) ? d : 32'hDEAD_BEEF;
            tick();
            ack = 1'b0;
        end
        chk("bus_bound_cyc", cyc, 1'b0);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
        cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; ack = 1'b0; rdat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", cyc, 1'b0);
        chk("rst_stb", stb, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_rdat", rsp_dat, 32'h0);
        chk("rst_bus", {sel, adr, wdat}, 68'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", cmd_ready, 1'b1);

        ack = 1'b1;
        rdat = 32'h0BAD_0BAD;
        tick();
        tick();
        ack = 1'b0;
        chk("idle_ack_busy", busy, 1'b0);
        chk("idle_ack_valid", rsp_valid, 1'b0);
        chk("idle_ack_cyc", cyc, 1'b0);

        issue(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001);
        chk("wr_cyc", cyc, 1'b1);
        chk("wr_stb", stb, 1'b1);
        chk("wr_we", we, 1'b1);
        chk("wr_sel", sel, 4'hF);
        chk("wr_adr", adr, 32'h3000_0004);
        chk("wr_dat", wdat, 32'hA5A5_0001);
        chk("wr_ready", cmd_ready, 1'b0);
        chk("wr_valid_early", rsp_valid, 1'b0);
        bus_resp(1, 32'hFFFF_0000, n, st);
        chk("wr_ncyc", n, 1);
        chk("wr_valid", rsp_valid, 1'b1);
        chk("wr_rdat", rsp_dat, 32'h0);
        chk("wr_err", rsp_err, 1'b0);
        chk("wr_we_low", we, 1'b0);
        chk("wr_dat_low", wdat, 32'h0);
        take_rsp();
        chk("wr_done_valid", rsp_valid, 1'b0);
        chk("wr_done_ready", cmd_ready, 1'b1);

        issue(1'b0, 4'hF, 32'h3000_0000, 32'h5555_AAAA);
        chk("rd_we", we, 1'b0);
        bus_resp(4, 32'h1234_5678, n, st);
        chk("rd_ncyc", n, 4);
        chk("rd_stable", st, 1'b1);
        chk("rd_valid", rsp_valid, 1'b1);
        chk("rd_data", rsp_dat, 32'h1234_5678);
        chk("rd_err", rsp_err, 1'b0);

        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'h3;
        cmd_adr = 32'h0000_0010; cmd_dat = 32'h0000_0077;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ack  = (i % 2 == 0);
            rdat = 32'hBAD0_0000;
            tick();
            if (!rsp_valid || rsp_dat !== 32'h1234_5678 ||
                cmd_ready || cyc || !busy) bad = 1'b1;
        end
        ack = 1'b0;
        chk("hold_stable", bad, 1'b0);
        take_rsp();
        chk("rel_ready", cmd_ready, 1'b1);
        chk("rel_valid", rsp_valid, 1'b0);
        chk("rel_cyc", cyc, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("sec_cyc", cyc, 1'b1);
        chk("sec_adr", adr, 32'h0000_0010);
        chk("sec_sel", sel, 4'h3);
        bus_resp(2, 32'h0, n, st);
        chk("sec_ncyc", n, 2);
        chk("sec_valid", rsp_valid, 1'b1);
        take_rsp();

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        bus_resp(0, 32'h0, n, st);
        chk("to_ncyc", n, 16);
        chk("to_valid", rsp_valid, 1'b1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_dat", rsp_dat, 32'h0);
        take_rsp();
        issue(1'b0, 4'hF, 32'h0000_0044, 32'h0);
        bus_resp(16, 32'hCAFE_0016, n, st);
        chk("to_edge_ncyc", n, 16);
        chk("to_edge_err", rsp_err, 1'b0);
        chk("to_edge_dat", rsp_dat, 32'hCAFE_0016);
        take_rsp();
`else
        issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        bus_resp(41, 32'hCAFE_0041, n, st);
        chk("wait_ncyc", n, 41);
        chk("wait_err", rsp_err, 1'b0);
        chk("wait_dat", rsp_dat, 32'hCAFE_0041);
        take_rsp();
`endif

        issue(1'b0, 4'hF, 32'h0000_0050, 32'h0);
        tick();
        chk("mid_cyc", cyc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", cyc, 1'b0);
        chk("arst_stb", stb, 1'b0);
        chk("arst_busy", busy, 1'b0);
        #1;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid || cyc) bad = 1'b1;
        end
        chk("arst_no_rsp", bad, 1'b0);
        issue(1'b1, 4'h1, 32'h0000_0060, 32'h0000_00AB);
        chk("post_adr", adr, 32'h0000_0060);
        bus_resp(1, 32'h0, n, st);
        chk("post_valid", rsp_valid, 1'b1);
        chk("post_err", rsp_err, 1'b0);
        take_rsp();
        chk("post_ready", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
